// File: rtl/jstk_pkg.sv
// -----------------------------------------------------------------------------
// jstk_pkg
// Shared definitions for the PmodJSTK SPI reader: the frame-sequencer state
// encoding, frame geometry, the LED command prefix sent in byte 0, and the
// helper that turns a lo/hi byte pair into an 11-bit axis word.
// -----------------------------------------------------------------------------
package jstk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        HOLD,
        DONE
    } jstk_state_e;

    localparam int         JSTK_BYTES     = 5;
    localparam logic [5:0] LED_CMD_PREFIX = 6'b100000;
    localparam int         DATA_W         = 10;
    localparam int         VAL_W          = 11;

    // The joystick reports a 10-bit axis as an 8-bit low byte plus the two
    // LSBs of the high byte; the word handed downstream is zero-extended.
    function automatic logic [VAL_W-1:0] pack_axis(input logic [7:0] lo,
                                                   input logic [1:0] hi);
        logic [DATA_W-1:0] raw;
        raw = {hi, lo};
        return {1'b0, raw};
    endfunction

endpackage

// File: rtl/jstk_spi_reader_if.sv
// -----------------------------------------------------------------------------
// jstk_spi_reader_if
// Bundles the joystick SPI pins and the decoded sample outputs.
//   sclk, mosi, ss : SPI pins driven by the reader (ss active-low)
//   miso           : SPI data returned by the joystick
//   x_val, y_val   : {1'b0, axis[9:0]}
//   btn            : button bits [2:0]
//   data_valid     : one-cycle strobe when x_val/y_val/btn update
//   busy           : frame in progress
// master = the reader, slave = the joystick / consumer side.
// -----------------------------------------------------------------------------
interface jstk_spi_reader_if;

    logic                       sclk;
    logic                       mosi;
    logic                       miso;
    logic                       ss;
    logic [jstk_pkg::VAL_W-1:0] x_val;
    logic [jstk_pkg::VAL_W-1:0] y_val;
    logic [2:0]                 btn;
    logic                       data_valid;
    logic                       busy;

    modport master (
        output sclk, mosi, ss, x_val, y_val, btn, data_valid, busy,
        input  miso
    );

    modport slave (
        input  sclk, mosi, ss, x_val, y_val, btn, data_valid, busy,
        output miso
    );

endinterface

// File: rtl/jstk_spi_reader_shift.sv
// -----------------------------------------------------------------------------
// spi_byte_shift
// One SPI mode-0 byte transfer, MSB first.
//   clk, rst : system clock, asynchronous active-low reset
//   start    : one-cycle request; tx_byte is captured on the same edge
//   tx_byte  : byte to send
//   miso     : serial input, sampled on each sclk rising edge
//   sclk     : SPI clock, idles low, half-period CLK_DIV clk cycles
//   mosi     : serial output, first bit valid from the start edge, updated
//              on sclk falling edges, 0 when idle
//   rx_byte  : received byte, valid from the done pulse on
//   done     : one-cycle pulse after the 8th sclk falling edge
// -----------------------------------------------------------------------------
module spi_byte_shift #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_byte,
    output logic       done
);

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       tx_sh;   // bits still to send after the one on mosi
    logic [7:0]       rx_sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_byte <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active  <= 1'b1;
                div_cnt <= '0;
                bit_cnt <= '0;
                sclk    <= 1'b0;
                mosi    <= tx_byte[7];
                tx_sh   <= tx_byte[6:0];
            end else if (active) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    if (!sclk) begin
                        // rising edge: capture the slave's bit
                        sclk  <= 1'b1;
                        rx_sh <= {rx_sh[6:0], miso};
                    end else begin
                        // falling edge: present the next bit or finish
                        sclk <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            active  <= 1'b0;
                            mosi    <= 1'b0;
                            rx_byte <= rx_sh;
                            done    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            mosi    <= tx_sh[6];
                            tx_sh   <= {tx_sh[5:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/jstk_spi_reader.sv
// -----------------------------------------------------------------------------
// jstk_spi_reader
// Periodically polls a PmodJSTK over SPI mode 0 and publishes the decoded
// axes and buttons. A frame is 5 bytes (X_lo, X_hi, Y_lo, Y_hi, buttons);
// byte 0 on mosi carries the LED command, the rest are zero.
//   clk  : system clock
//   rst  : asynchronous active-low reset; aborts any frame at once
//   en   : polling enable; clearing it stops new frames, not the current one
//   led  : LED command bits, sampled at frame start
//   bus  : SPI pins plus x_val/y_val/btn/data_valid/busy (master side)
// -----------------------------------------------------------------------------
module jstk_spi_reader
    import jstk_pkg::*;
#(
    parameter int CLK_DIV     = 50,
    parameter int POLL_CYCLES = 1_000_000,
    parameter int GAP_CYCLES  = 1500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        led,
    jstk_spi_reader_if.master bus
);

    localparam int                POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int                GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0]        LAST_BYTE = 3'(JSTK_BYTES - 1);

    jstk_state_e       state;
    jstk_state_e       state_nxt;
    logic [POLL_W-1:0] poll_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [2:0]        byte_cnt;
    logic [7:0]        tx_byte;
    logic              start_req;
    logic              gap_done;
    logic              start_shift;
    logic              shift_done;
    logic [7:0]        rx_byte;
    logic              sclk_w;
    logic              mosi_w;

    logic [7:0]        x_lo;
    logic [1:0]        x_hi;
    logic [7:0]        y_lo;
    logic [1:0]        y_hi;
    logic [2:0]        btn_raw;

    logic              ss_q;
    logic              busy_q;
    logic              valid_q;
    logic [VAL_W-1:0]  x_q;
    logic [VAL_W-1:0]  y_q;
    logic [2:0]        btn_q;

    // A request is a single-cycle event at the counter wrap; if the FSM is
    // not in IDLE on that cycle the request is simply lost.
    assign start_req = en && (poll_cnt == POLL_LAST);
    assign gap_done  = (gap_cnt == GAP_LAST);

    // ---- byte shifter ----
    spi_byte_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (start_shift),
        .tx_byte (tx_byte),
        .miso    (bus.miso),
        .sclk    (sclk_w),
        .mosi    (mosi_w),
        .rx_byte (rx_byte),
        .done    (shift_done)
    );

    // ---- frame sequencer: next state ----
    always_comb begin
        state_nxt   = state;
        start_shift = 1'b0;
        case (state)
            IDLE:  if (start_req) state_nxt = SETUP;
            SETUP: if (gap_done) begin
                       state_nxt   = SHIFT;
                       start_shift = 1'b1;
                   end
            SHIFT: if (shift_done) state_nxt = (byte_cnt == LAST_BYTE) ? HOLD : GAP;
            GAP:   if (gap_done) begin
                       state_nxt   = SHIFT;
                       start_shift = 1'b1;
                   end
            HOLD:  if (gap_done) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- frame sequencer: registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            byte_cnt <= '0;
            tx_byte  <= '0;
            x_lo     <= '0;
            x_hi     <= '0;
            y_lo     <= '0;
            y_hi     <= '0;
            btn_raw  <= '0;
            ss_q     <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            btn_q    <= '0;
        end else begin
            state   <= state_nxt;
            valid_q <= 1'b0;

            if (!en)
                poll_cnt <= '0;
            else if (poll_cnt == POLL_LAST)
                poll_cnt <= '0;
            else
                poll_cnt <= poll_cnt + 1'b1;

            // gap_cnt restarts on every state change so SETUP/GAP/HOLD each
            // last exactly GAP_CYCLES
            if (state_nxt != state)
                gap_cnt <= '0;
            else if (state == SETUP || state == GAP || state == HOLD)
                gap_cnt <= gap_cnt + 1'b1;

            case (state)
                IDLE: if (start_req) begin
                    ss_q     <= 1'b0;
                    busy_q   <= 1'b1;
                    byte_cnt <= '0;
                    tx_byte  <= {LED_CMD_PREFIX, led};
                end
                SHIFT: if (shift_done) begin
                    tx_byte <= 8'h00;
                    case (byte_cnt)
                        3'd0:    x_lo    <= rx_byte;
                        3'd1:    x_hi    <= rx_byte[1:0];
                        3'd2:    y_lo    <= rx_byte;
                        3'd3:    y_hi    <= rx_byte[1:0];
                        default: btn_raw <= rx_byte[2:0];
                    endcase
                end
                GAP: if (gap_done) begin
                    byte_cnt <= byte_cnt + 3'd1;
                end
                HOLD: if (gap_done) begin
                    ss_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    x_q     <= pack_axis(x_lo, x_hi);
                    y_q     <= pack_axis(y_lo, y_hi);
                    btn_q   <= btn_raw;
                end
                default: ;
            endcase
        end
    end

    assign bus.sclk       = sclk_w;
    assign bus.mosi       = mosi_w;
    assign bus.ss         = ss_q;
    assign bus.busy       = busy_q;
    assign bus.data_valid = valid_q;
    assign bus.x_val      = x_q;
    assign bus.y_val      = y_q;
    assign bus.btn        = btn_q;

endmodule

// File: tb/tb_jstk_spi_reader.sv
`timescale 1ns/1ps
module tb_jstk_spi_reader;
    import jstk_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int GAP     = 4;
    localparam int POLL_A  = 400;
    localparam int POLL_B  = 100;

    typedef struct packed {
        logic [1:0]  led;
        logic [39:0] miso_bytes;   // {b0, b1, b2, b3, b4}
        logic [10:0] x;
        logic [10:0] y;
        logic [2:0]  btn;
        logic [7:0]  mosi0;
    } vec_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [2:0]  btn;
        logic [7:0]  mosi0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, rst_b, en_b;
    logic [1:0] led_a, led_b;

    jstk_spi_reader_if bus_a();
    jstk_spi_reader_if bus_b();

    jstk_spi_reader #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL_A), .GAP_CYCLES(GAP)) dut_a (
        .clk (clk), .rst (rst_a), .en (en_a), .led (led_a), .bus (bus_a)
    );
    jstk_spi_reader #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL_B), .GAP_CYCLES(GAP)) dut_b (
        .clk (clk), .rst (rst_b), .en (en_b), .led (led_b), .bus (bus_b)
    );

    assign bus_b.miso = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---- joystick slave model for dut_a ----
    logic [7:0] slv_bytes [5];
    logic [7:0] mosi_cap [5];
    logic [7:0] cap_sh = 8'h00;
    int         slv_byte = 0;
    int         slv_bit = 0;
    logic       sl_prev_ss = 1'b1;
    logic       sl_prev_sclk = 1'b0;

    always @(bus_a.ss or bus_a.sclk) begin
        if (sl_prev_ss && !bus_a.ss) begin
            slv_byte = 0;
            slv_bit  = 0;
        end else if (!bus_a.ss && !sl_prev_sclk && bus_a.sclk) begin
            cap_sh = {cap_sh[6:0], bus_a.mosi};
        end else if (!bus_a.ss && sl_prev_sclk && !bus_a.sclk) begin
            slv_bit++;
            if (slv_bit == 8) begin
                if (slv_byte < 5) mosi_cap[slv_byte] = cap_sh;
                slv_byte++;
                slv_bit = 0;
            end
        end
        if (!bus_a.ss && slv_byte < 5)
            bus_a.miso = slv_bytes[slv_byte][7 - slv_bit];
        else
            bus_a.miso = 1'b0;
        sl_prev_ss   = bus_a.ss;
        sl_prev_sclk = bus_a.sclk;
    end

    // ---- bus monitor for dut_a ----
    int          sclk_rises = 0, rise_base = 0, ss_falls = 0, dv_cycles = 0;
    int          sclk_viol = 0, mosi_viol = 0, stab_viol = 0;
    logic        mon_ss = 1'b1, mon_sclk = 1'b0, mon_mosi = 1'b0;
    logic [10:0] stab_x = '0, stab_y = '0;
    logic [2:0]  stab_b = '0;

    always @(negedge clk) begin
        if (bus_a.ss && bus_a.sclk) sclk_viol <= sclk_viol + 1;
        if (bus_a.sclk && bus_a.mosi !== mon_mosi) mosi_viol <= mosi_viol + 1;
        if (!mon_sclk && bus_a.sclk) sclk_rises <= sclk_rises + 1;
        if (mon_ss && !bus_a.ss) begin
            ss_falls  <= ss_falls + 1;
            rise_base <= sclk_rises;
        end
        if (bus_a.data_valid) dv_cycles <= dv_cycles + 1;
        if (!rst_a) begin
            stab_x <= '0; stab_y <= '0; stab_b <= '0;
        end else begin
            if (!bus_a.data_valid &&
                (bus_a.x_val !== stab_x || bus_a.y_val !== stab_y || bus_a.btn !== stab_b))
                stab_viol <= stab_viol + 1;
            stab_x <= bus_a.x_val; stab_y <= bus_a.y_val; stab_b <= bus_a.btn;
        end
        mon_ss   <= bus_a.ss;
        mon_sclk <= bus_a.sclk;
        mon_mosi <= bus_a.mosi;
    end

    // ---- scoreboard ----
    exp_t sb_q[$];
    vec_t vecs[5];

    task automatic load_frame(input vec_t v, input bit push);
        exp_t e;
        led_a = v.led;
        for (int i = 0; i < 5; i++) slv_bytes[i] = v.miso_bytes[39 - 8*i -: 8];
        e.x = v.x; e.y = v.y; e.btn = v.btn; e.mosi0 = v.mosi0;
        if (push) sb_q.push_back(e);
    endtask

    task automatic wait_frame(input string tag);
        bit   seen = 0;
        exp_t e;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (bus_a.data_valid) seen = 1;
        end
        chk({tag, "_dv_seen"}, 32'(seen), 1);
        if (!seen) return;
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({tag, "_x_val"}, 32'(bus_a.x_val), 32'(e.x));
        chk({tag, "_y_val"}, 32'(bus_a.y_val), 32'(e.y));
        chk({tag, "_btn"}, 32'(bus_a.btn), 32'(e.btn));
        chk({tag, "_ss_high_with_dv"}, 32'(bus_a.ss), 1);
        chk({tag, "_busy_low_with_dv"}, 32'(bus_a.busy), 0);
        chk({tag, "_mosi_byte0"}, 32'(mosi_cap[0]), 32'(e.mosi0));
        chk({tag, "_mosi_bytes1to4"}, {mosi_cap[1], mosi_cap[2], mosi_cap[3], mosi_cap[4]}, 0);
        chk({tag, "_sclk_rises"}, sclk_rises - rise_base, 40);
        @(negedge clk);
        chk({tag, "_dv_one_cycle"}, 32'(bus_a.data_valid), 0);
    endtask

    task automatic wait_ss_fall(input string tag, output int n);
        bit fell = 0;
        n = 0;
        for (int k = 0; k < 2000 && !fell; k++) begin
            @(posedge clk);
            n++;
            #1;
            if (!bus_a.ss) fell = 1;
        end
        chk({tag, "_ss_fell"}, 32'(fell), 1);
    endtask

    task automatic wait_byte(input string tag, input int idx);
        bit hit = 0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge clk);
            if (slv_byte == idx) hit = 1;
        end
        chk({tag, "_reached_byte"}, 32'(hit), 1);
    endtask

    // ---- dut_b: poll period shorter than a frame ----
    bit done_b = 0;
    int b_e = 0, b_d = -1, b_starts = 0;
    logic b_prev_ss = 1'b1;

    initial begin
        rst_b = 1'b0; en_b = 1'b1; led_b = 2'b00;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        for (int k = 0; k < 1200 && b_starts < 4; k++) begin
            @(posedge clk);
            b_e++;
            #1;
            if (b_prev_ss && !bus_b.ss) begin
                b_starts++;
                chk("b_start_on_wrap", b_e % POLL_B, 0);
                if (b_d < 0) chk("b_first_start", b_e, POLL_B);
                else         chk("b_start_first_wrap_after_done", b_e,
                                 ((b_d + 2 + POLL_B - 1) / POLL_B) * POLL_B);
                chk("b_busy_at_start", 32'(bus_b.busy), 1);
            end
            if (bus_b.data_valid) begin
                b_d = b_e;
                chk("b_ss_high_with_dv", 32'(bus_b.ss), 1);
                chk("b_x_val_zero_slave", 32'(bus_b.x_val), 0);
            end
            b_prev_ss = bus_b.ss;
        end
        chk("b_frame_count", b_starts, 4);
        done_b = 1;
    end

    // ---- main sequence on dut_a ----
    initial begin
        int n;
        int snap;

        vecs[0] = '{led:2'b10, miso_bytes:40'h2C_03_FF_01_05, x:11'h32C, y:11'h1FF, btn:3'b101, mosi0:8'h82};
        vecs[1] = '{led:2'b01, miso_bytes:40'h00_00_00_00_00, x:11'h000, y:11'h000, btn:3'b000, mosi0:8'h81};
        vecs[2] = '{led:2'b11, miso_bytes:40'hFF_FF_FF_FF_FF, x:11'h3FF, y:11'h3FF, btn:3'b111, mosi0:8'h83};
        vecs[3] = '{led:2'b00, miso_bytes:40'h55_FE_AA_02_F8, x:11'h255, y:11'h2AA, btn:3'b000, mosi0:8'h80};
        vecs[4] = '{led:2'b10, miso_bytes:40'h01_FC_80_7D_03, x:11'h001, y:11'h180, btn:3'b011, mosi0:8'h82};

        rst_a = 1'b0; en_a = 1'b1;
        load_frame(vecs[0], 1);
        repeat (3) @(negedge clk);

        chk("rst_sclk", 32'(bus_a.sclk), 0);
        chk("rst_mosi", 32'(bus_a.mosi), 0);
        chk("rst_ss", 32'(bus_a.ss), 1);
        chk("rst_x_val", 32'(bus_a.x_val), 0);
        chk("rst_y_val", 32'(bus_a.y_val), 0);
        chk("rst_btn", 32'(bus_a.btn), 0);
        chk("rst_data_valid", 32'(bus_a.data_valid), 0);
        chk("rst_busy", 32'(bus_a.busy), 0);

        rst_a = 1'b1;
        wait_ss_fall("first", n);
        chk("first_ss_fall_delay", n, POLL_A);
        chk("first_busy", 32'(bus_a.busy), 1);
        chk("first_x_still_reset", 32'(bus_a.x_val), 0);
        wait_frame("v0");

        for (int i = 1; i < 5; i++) begin
            load_frame(vecs[i], 1);
            wait_frame($sformatf("v%0d", i));
        end

        // en dropped while byte 2 is on the wire
        load_frame(vecs[3], 1);
        wait_ss_fall("endrop", n);
        wait_byte("endrop", 2);
        repeat (6) @(negedge clk);
        en_a = 1'b0;
        wait_frame("endrop");
        snap = ss_falls;
        repeat (900) @(negedge clk);
        chk("no_ss_while_en0", ss_falls - snap, 0);
        chk("ss_idle_while_en0", 32'(bus_a.ss), 1);

        load_frame(vecs[4], 1);
        en_a = 1'b1;
        wait_ss_fall("reen", n);
        chk("reen_ss_fall_delay", n, POLL_A);
        wait_frame("reen");

        // reset pulse during byte 3
        load_frame(vecs[2], 0);
        wait_ss_fall("abort", n);
        wait_byte("abort", 3);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #3 rst_a = 1'b0;
        #1;
        chk("abort_ss", 32'(bus_a.ss), 1);
        chk("abort_sclk", 32'(bus_a.sclk), 0);
        chk("abort_busy", 32'(bus_a.busy), 0);
        chk("abort_x_val", 32'(bus_a.x_val), 0);
        chk("abort_dv", 32'(bus_a.data_valid), 0);
        #2 rst_a = 1'b1;
        snap = dv_cycles;
        repeat (350) @(negedge clk);
        chk("abort_no_dv", dv_cycles - snap, 0);
        chk("abort_x_held", 32'(bus_a.x_val), 0);
        chk("sb_drained", sb_q.size(), 0);

        for (int k = 0; k < 3000 && !done_b; k++) @(negedge clk);
        chk("b_finished", 32'(done_b), 1);

        chk("sclk_low_while_ss_high", sclk_viol, 0);
        chk("mosi_stable_while_sclk_high", mosi_viol, 0);
        chk("outputs_change_only_with_dv", stab_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
